// File: rtl/zymason_seg_scroller.sv
// rtl/zymason_seg_scroller.sv - seven-segment digit store with nibble-wise write cursor and timed scan
// Optional build macro ZYMASON_CURSOR_BLINK_EN blanks seg_out in write mode on the prescaler MSB.
module zymason_seg_scroller #(
   parameter int NUM_DIGITS = 8,
   parameter int PRE_W      = 9,
   parameter int SPD_W      = 4,
   localparam int PW        = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  RW,
   input  logic                  sel,
   input  logic [3:0]            pin_in,
   input  logic [SPD_W-1:0]      spd,
   output logic [6:0]            seg_out,
   output logic [NUM_DIGITS-1:0] dig_en,
   output logic [PW-1:0]         ptr,
   output logic                  mode_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_WLO  = 2'd2,
      S_WHI  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [PRE_W-1:0] r_count;
   logic [SPD_W-1:0] r_div;
   logic [PW-1:0]    r_ptr;
   logic [6:0]       r_mem [NUM_DIGITS];

   logic w_tick;
   logic w_pulse;
   logic w_wr_adv;
   logic w_adv;
   logic w_wr_lo;
   logic w_wr_hi;
   logic w_blank;

   assign w_tick   = (r_count == '0);
   assign w_pulse  = (r_state == S_SCAN) && !RW && w_tick && (spd != '0) && (r_div == spd);
   assign w_wr_adv = (r_state == S_WHI) && RW && !sel;
   assign w_adv    = w_pulse || w_wr_adv;
   assign w_wr_lo  = (r_state == S_WLO) && RW && !sel;
   assign w_wr_hi  = (r_state == S_WHI) && RW && sel;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  w_next_state = RW ? S_WLO : S_SCAN;
         S_SCAN:  w_next_state = RW ? S_WLO : S_SCAN;
         S_WLO:   w_next_state = sel ? S_WHI : S_WLO;
         S_WHI: begin
            if (!RW)
               w_next_state = S_SCAN;
            else if (!sel)
               w_next_state = S_WLO;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         r_count <= r_count + 1'b1;
      end
   end

   // Divider only runs in SCAN so every scan entry starts a full period.
   always_ff @(posedge clock) begin
      if (reset || (r_state != S_SCAN) || w_pulse)
         r_div <= '0;
      else if (w_tick && !RW)
         r_div <= r_div + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         r_ptr <= '0;
      else if (w_adv)
         r_ptr <= (r_ptr == PW'(NUM_DIGITS - 1)) ? '0 : r_ptr + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            r_mem[i] <= '0;
      end else if (w_wr_lo) begin
         r_mem[r_ptr][3:0] <= pin_in;
      end else if (w_wr_hi) begin
         r_mem[r_ptr][6:4] <= pin_in[2:0];
      end
   end

`ifdef ZYMASON_CURSOR_BLINK_EN
   assign w_blank = ((r_state == S_WLO) || (r_state == S_WHI)) && r_count[PRE_W-1];
`else
   assign w_blank = 1'b0;
`endif

   assign seg_out  = w_blank ? 7'h00 : r_mem[r_ptr];
   assign dig_en   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_ptr;
   assign ptr      = r_ptr;
   assign mode_out = (r_state == S_WLO) || (r_state == S_WHI);

endmodule
